// File: rtl/graydec_sync_pkg.sv
// Shared Gray-code helpers and step classification for the Gray count receiver.
// Functions work on a fixed 32-bit word; callers zero-extend narrower codes.
package graydec_sync_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [2:0] {
        KIND_FILL    = 3'd0,
        KIND_PRIME   = 3'd1,
        KIND_HOLD    = 3'd2,
        KIND_STEP    = 3'd3,
        KIND_ILLEGAL = 3'd4
    } step_kind_e;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input word_t v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/graydec_sync_sync_chain.sv
// Multi-flop synchronizer with async clear, plus a fill marker that rises once
// every stage holds a real sample taken after reset release.
module sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             filled
);

    logic [WIDTH-1:0]       stage [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
            fill <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign q      = stage[SYNC_STAGES-1];
    assign filled = fill[SYNC_STAGES-1];

endmodule

// File: rtl/graydec_sync.sv
// Gray count receiver: synchronizes an async Gray word, decodes it to binary and
// reports direction, wrap and illegal multi-bit steps as one-cycle pulses.
module graydec_sync
    import graydec_sync_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Ngray,
    output logic [WIDTH-1:0] Nbin,
    output logic             changed,
    output logic             dir,
    output logic             wrap,
    output logic             step_err,
    output logic             err_sticky
);

    localparam word_t MASK = word_t'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] g_s;
    logic             filled;
    logic [WIDTH-1:0] g_prev;
    logic             primed;

    word_t      g_ext;
    word_t      prev_ext;
    word_t      nbin_ext;
    word_t      dec_ext;
    logic [5:0] flips;
    logic       is_up;
    logic       is_wrap;
    step_kind_e kind;

    sync_chain #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (Ngray),
        .q      (g_s),
        .filled (filled)
    );

    always_comb begin
        g_ext    = '0;
        prev_ext = '0;
        nbin_ext = '0;
        g_ext[WIDTH-1:0]    = g_s;
        prev_ext[WIDTH-1:0] = g_prev;
        nbin_ext[WIDTH-1:0] = Nbin;
    end

    assign dec_ext = gray2bin(g_ext);
    assign flips   = popcount(g_ext ^ prev_ext);
    assign is_up   = (dec_ext == ((nbin_ext + word_t'(1)) & MASK));
    assign is_wrap = ((nbin_ext == MASK) && (dec_ext == '0)) ||
                     ((nbin_ext == '0) && (dec_ext == MASK));

    // Priming waits for the chain to fill so the first compare never sees the
    // cleared flops as a previous value.
    always_comb begin
        kind = KIND_FILL;
        if (!filled) begin
            kind = KIND_FILL;
        end else if (!primed) begin
            kind = KIND_PRIME;
        end else if (flips == 6'd0) begin
            kind = KIND_HOLD;
        end else if (flips == 6'd1) begin
            kind = KIND_STEP;
        end else begin
            kind = KIND_ILLEGAL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            g_prev     <= '0;
            primed     <= 1'b0;
            Nbin       <= '0;
            changed    <= 1'b0;
            dir        <= 1'b0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            changed  <= 1'b0;
            wrap     <= 1'b0;
            step_err <= 1'b0;
            case (kind)
                KIND_PRIME: begin
                    primed  <= 1'b1;
                    g_prev  <= g_s;
                    Nbin    <= dec_ext[WIDTH-1:0];
                    changed <= 1'b1;
                    dir     <= 1'b0;
                end
                KIND_STEP: begin
                    g_prev  <= g_s;
                    Nbin    <= dec_ext[WIDTH-1:0];
                    changed <= 1'b1;
                    dir     <= is_up;
                    wrap    <= is_wrap;
                end
                KIND_ILLEGAL: begin
                    g_prev     <= g_s;
                    Nbin       <= dec_ext[WIDTH-1:0];
                    changed    <= 1'b1;
                    step_err   <= 1'b1;
                    err_sticky <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
